// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON job sequencer: FSM states, mode codes,
// datapath widths and the input block-count helper.
package ascon_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_HASH = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam int BLK_W = 64;
    localparam int TAG_W = 128;
    localparam int KEY_W = 128;

    // Whole 64-bit blocks of AD plus whole blocks of PT/CT; the result always fits 5 bits.
    function automatic logic [4:0] calc_n_in(input logic [3:0] ad_len, input logic [6:0] datalen);
        logic [4:0] ad_blks;
        logic [7:0] dt_blks;
        ad_blks = ({1'b0, ad_len} + 5'd7) >> 3;
        dt_blks = ({1'b0, datalen} + 8'd7) >> 3;
        return ad_blks + dt_blks[4:0];
    endfunction

endpackage

// File: rtl/ascon_seq_ctrl_if.sv
// Host-side command, input-block, CT-stream and tag handshakes of the ASCON sequencer.
// master = host driving jobs in, slave = the sequencer.
interface ascon_seq_ctrl_if;
    import ascon_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_mode;
    logic [3:0]       cmd_ad_len;
    logic [6:0]       cmd_datalen;
    logic [KEY_W-1:0] cmd_key;
    logic [KEY_W-1:0] cmd_nonce;

    logic             blk_in_valid;
    logic             blk_in_ready;
    logic [BLK_W-1:0] blk_in_data;

    logic             ct_out_valid;
    logic             ct_out_ready;
    logic [BLK_W-1:0] ct_out_data;

    logic             tag_valid;
    logic             tag_ready;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output cmd_valid, cmd_mode, cmd_ad_len, cmd_datalen, cmd_key, cmd_nonce,
        output blk_in_valid, blk_in_data, ct_out_ready, tag_ready,
        input  cmd_ready, blk_in_ready, ct_out_valid, ct_out_data, tag_valid, tag_out
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_ad_len, cmd_datalen, cmd_key, cmd_nonce,
        input  blk_in_valid, blk_in_data, ct_out_ready, tag_ready,
        output cmd_ready, blk_in_ready, ct_out_valid, ct_out_data, tag_valid, tag_out
    );

endinterface

// File: rtl/ascon_ct_fifo.sv
// Synchronous CT output FIFO with flush; a push into a full FIFO is accepted only when a
// pop happens in the same cycle, otherwise it is dropped and overflow_o pulses.
module ascon_ct_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign overflow_o = push_i && full_o && !pop_i;
    assign dout_o     = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/ascon_seq_ctrl.sv
// ASCON job sequencer: accepts a command, buffers its AD/PT blocks, starts the core,
// serves block requests, queues CT and hands off the tag. Optional RUN watchdog: ASCON_SEQ_TIMEOUT_EN.
module ascon_seq_ctrl
    import ascon_pkg::*;
#(
    parameter int MAX_BLKS       = 6,
    parameter int CT_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    ascon_seq_ctrl_if.slave  host,
    output logic             core_start,
    output logic [1:0]       core_mode,
    output logic [3:0]       core_ad_len,
    output logic [6:0]       core_datalen,
    output logic [KEY_W-1:0] core_key,
    output logic [KEY_W-1:0] core_nonce,
    input  logic [2:0]       core_block_request,
    output logic [BLK_W-1:0] core_blockout,
    input  logic [3:0]       core_state,
    input  logic [BLK_W-1:0] core_ctblock,
    input  logic             core_ctv,
    input  logic             core_tv,
    input  logic [TAG_W-1:0] core_tag,
    output logic             busy,
    output logic [2:0]       err
);
    localparam int IW = (MAX_BLKS > 1) ? $clog2(MAX_BLKS) : 1;

    seq_state_t       state_q, state_d;
    logic [BLK_W-1:0] buf_q [MAX_BLKS];
    logic [4:0]       wr_ptr_q;
    logic [4:0]       n_in_q;
    logic [4:0]       n_in;
    logic [TAG_W-1:0] tag_q;
    logic             tag_valid_q;
    logic [2:0]       err_q;

    logic cmd_acc, cmd_bad, blk_hs, last_blk, tag_hs;
    logic ct_push, ct_pop, fifo_empty, fifo_full, fifo_ovf, timeout;

    // The core's state is informational only; the sequencer is driven by ctv/tv.
    logic unused_core_state;
    assign unused_core_state = ^core_state;

    assign n_in     = calc_n_in(host.cmd_ad_len, host.cmd_datalen);
    assign cmd_acc  = host.cmd_valid && host.cmd_ready;
    assign cmd_bad  = (host.cmd_mode == MODE_RSVD) || (n_in > 5'(MAX_BLKS));
    assign blk_hs   = host.blk_in_valid && (state_q == LOAD);
    assign last_blk = blk_hs && (wr_ptr_q == n_in_q - 5'd1);
    assign tag_hs   = host.tag_valid && host.tag_ready;
    assign ct_push  = core_ctv && ((state_q == RUN) || (state_q == DONE));
    assign ct_pop   = host.ct_out_valid && host.ct_out_ready;

    assign host.cmd_ready    = (state_q == IDLE) && !wb_rst_i;
    assign host.blk_in_ready = (state_q == LOAD);
    assign host.tag_valid    = tag_valid_q;
    assign host.tag_out      = tag_q;
    assign host.ct_out_valid = !fifo_empty;
    assign core_start        = (state_q == START);
    assign busy              = (state_q != IDLE);
    assign err               = err_q;

`ifdef ASCON_SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)               tmo_cnt_q <= '0;
        else if (state_q == START)  tmo_cnt_q <= '0;
        else if (state_q == RUN)    tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    assign timeout = (state_q == RUN) && !core_tv && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        core_blockout = '0;
        if (int'(core_block_request) < MAX_BLKS) core_blockout = buf_q[core_block_request];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_acc && !cmd_bad) state_d = (n_in == 5'd0) ? START : LOAD;
            end
            LOAD:  if (last_blk) state_d = START;
            START: state_d = RUN;
            RUN: begin
                if (core_tv)      state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            // Leave only once the tag is taken and no CT remains or is arriving.
            DONE: begin
                if ((tag_hs || !tag_valid_q) && fifo_empty && !ct_push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            core_mode    <= '0;
            core_ad_len  <= '0;
            core_datalen <= '0;
            core_key     <= '0;
            core_nonce   <= '0;
            n_in_q       <= '0;
            wr_ptr_q     <= '0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            err_q        <= '0;
            for (int i = 0; i < MAX_BLKS; i++) buf_q[i] <= '0;
        end else begin
            if (cmd_acc) begin
                core_mode    <= host.cmd_mode;
                core_ad_len  <= host.cmd_ad_len;
                core_datalen <= host.cmd_datalen;
                core_key     <= host.cmd_key;
                core_nonce   <= host.cmd_nonce;
                n_in_q       <= n_in;
                wr_ptr_q     <= '0;
                err_q        <= {2'b00, cmd_bad};
            end else begin
                err_q <= err_q | {timeout, fifo_ovf, 1'b0};
            end
            if (blk_hs) begin
                if (int'(wr_ptr_q) < MAX_BLKS) buf_q[wr_ptr_q[IW-1:0]] <= host.blk_in_data;
                wr_ptr_q <= wr_ptr_q + 5'd1;
            end
            if ((state_q == RUN) && core_tv) begin
                tag_q       <= core_tag;
                tag_valid_q <= 1'b1;
            end else if (tag_hs) begin
                tag_valid_q <= 1'b0;
            end
        end
    end

    ascon_ct_fifo #(
        .DEPTH (CT_DEPTH),
        .WIDTH (BLK_W)
    ) u_ct_fifo (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .push_i     (ct_push),
        .pop_i      (ct_pop),
        .flush_i    (timeout),
        .din_i      (core_ctblock),
        .dout_o     (host.ct_out_data),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .overflow_o (fifo_ovf)
    );

    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule
